// File: rtl/ins_mem_seq.sv
// ins_mem_seq: writable instruction memory with boot-stub init, registered fetch handshake and load port.
module ins_mem_seq #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W = $clog2(DEPTH_WORDS),
  parameter logic [31:0] BOOT_WORD0 = 32'h20000001,
  parameter logic [31:0] BOOT_WORD1 = 32'h08000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic [31:0] instruction,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        fetch_fault,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        load_ready,
  output logic        load_err
);
  typedef enum logic {INIT, READY} state_t;
  state_t state;
  logic [IDX_W-1:0] cnt, f_idx, l_idx, wr_idx;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] wr_data;
  logic f_bad, l_bad, accept, wr_en;
  always_comb begin
    f_bad = fetch_addr[1:0] != 2'b0 || (fetch_addr >> (IDX_W + 2)) != 32'b0;
    l_bad = load_addr[1:0] != 2'b0 || (load_addr >> (IDX_W + 2)) != 32'b0;
    f_idx = fetch_addr[IDX_W+1:2];
    l_idx = load_addr[IDX_W+1:2];
    fetch_ready = state == READY && (!resp_valid || resp_ready);
    load_ready = state == READY;
    accept = fetch_req && fetch_ready;
    wr_en = !reset && (state == INIT || (load_en && !l_bad));
    wr_idx = state == INIT ? cnt : l_idx;
    wr_data = state == INIT ? (cnt == '0 ? BOOT_WORD0 : cnt == IDX_W'(1) ? BOOT_WORD1 : 32'b0) : load_data;
  end
  // Read uses the pre-edge array, so a same-cycle load to the fetched index returns the old word.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_idx] <= wr_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cnt <= '0;
      resp_valid <= 1'b0;
      fetch_fault <= 1'b0;
      instruction <= '0;
      load_err <= 1'b0;
    end else begin
      load_err <= load_en && (state == INIT || l_bad);
      if (state == INIT) begin
        cnt <= cnt + 1'b1;
        if (cnt == IDX_W'(DEPTH_WORDS - 1)) state <= READY;
      end
      if (accept) begin
        resp_valid <= 1'b1;
        instruction <= f_bad ? '0 : mem[f_idx];
        fetch_fault <= f_bad;
      end else if (resp_ready) resp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ins_mem_seq.sv
// tb_ins_mem_seq: directed scoreboard bench for ins_mem_seq.
module tb_ins_mem_seq;
  localparam int DEPTH = 256;
  logic clk = 0, reset = 1, fetch_req = 0, resp_ready = 1, load_en = 0;
  logic [31:0] fetch_addr = 0, load_addr = 0, load_data = 0;
  logic fetch_ready, resp_valid, fetch_fault, load_ready, load_err;
  logic [31:0] instruction;
  logic [32:0] exp_q [$];
  int checks = 0, errors = 0, pushed = 0, popped = 0, cyc;

  ins_mem_seq #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .instruction(instruction), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .fetch_fault(fetch_fault), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .load_ready(load_ready), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every accepted response must match the oldest expectation.
  always @(negedge clk)
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got %h with empty scoreboard", {fetch_fault, instruction});
      end else begin
        popped++;
        chk("resp", {fetch_fault, instruction}, exp_q.pop_front());
      end
    end

  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ef);
    int n;
    fetch_req = 1;
    fetch_addr = a;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (fetch_ready) break;
    end
    if (n == 50) chk("fetch_accept_timeout", 33'd0, 33'd1);
    else begin
      exp_q.push_back({ef, ei});
      pushed++;
    end
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d, input logic ee, input string name);
    load_en = 1;
    load_addr = a;
    load_data = d;
    @(posedge clk); #1;
    load_en = 0;
    chk(name, {32'b0, load_err}, {32'b0, ee});
    @(posedge clk); #1;
    chk({name, "_clear"}, {32'b0, load_err}, 33'd0);
  endtask

  task automatic pulse_reset();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic wait_ready(output int c);
    c = 0;
    while (!fetch_ready && c < 1000) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    pulse_reset();
    chk("rst_resp_valid", {32'b0, resp_valid}, 33'd0);
    chk("rst_instruction", {1'b0, instruction}, 33'd0);
    chk("rst_load_err", {32'b0, load_err}, 33'd0);
    chk("rst_ready", {31'b0, fetch_ready, load_ready}, 33'd0);
    wait_ready(cyc);
    chk("init_len", 33'(cyc), 33'(DEPTH));
    chk("load_ready_up", {32'b0, load_ready}, 33'd1);
    fetch(32'h0, 32'h20000001, 0);
    fetch(32'h4, 32'h08000000, 0);
    fetch(32'h8, 32'h00000000, 0);
    fetch_req = 0;
    fetch(32'h2, 32'h0, 1);
    fetch(32'h400, 32'h0, 1);
    fetch_req = 0;
    load(32'h401, 32'hFFFFFFFF, 1, "load_err_range");
    fetch(32'h0, 32'h20000001, 0);
    fetch_req = 0;
    load(32'h10, 32'h00221820, 0, "load_ok");
    fetch(32'h10, 32'h00221820, 0);
    load_en = 1;
    load_addr = 32'h10;
    load_data = 32'hDEADBEEF;
    fetch(32'h10, 32'h00221820, 0);
    load_en = 0;
    fetch(32'h10, 32'hDEADBEEF, 0);
    fetch_req = 0;
    @(posedge clk); #1;
    resp_ready = 0;
    fetch(32'h0, 32'h20000001, 0);
    fetch_addr = 32'h4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold", {resp_valid, instruction}, {1'b1, 32'h20000001});
      chk("stall_fetch_ready", {32'b0, fetch_ready}, 33'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1;
    fetch(32'h4, 32'h08000000, 0);
    fetch_req = 0;
    chk("after_stall", {resp_valid, instruction}, {1'b1, 32'h08000000});
    @(posedge clk); #1;
    load(32'h10, 32'h12345678, 0, "load_pre_reset");
    resp_ready = 0;
    fetch_req = 1;
    fetch_addr = 32'h10;
    @(posedge clk); #1;
    fetch_req = 0;
    chk("stalled_before_reset", {32'b0, resp_valid}, 33'd1);
    pulse_reset();
    chk("reset_drops_resp", {32'b0, resp_valid}, 33'd0);
    resp_ready = 1;
    repeat (100) @(posedge clk);
    #1;
    chk("init_mid_ready", {31'b0, fetch_ready, load_ready}, 33'd0);
    pulse_reset();
    wait_ready(cyc);
    chk("init_restart_len", 33'(cyc), 33'(DEPTH));
    fetch(32'h10, 32'h0, 0);
    fetch_req = 0;
    pulse_reset();
    @(posedge clk); #1;
    load(32'h8, 32'hCAFEF00D, 1, "load_err_init");
    wait_ready(cyc);
    chk("init_len3", 33'(cyc + 3), 33'(DEPTH));
    fetch(32'h8, 32'h0, 0);
    fetch(32'h4, 32'h08000000, 0);
    fetch_req = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 33'(exp_q.size()), 33'd0);
    chk("resp_count", 33'(popped), 33'(pushed));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ins_mem_seq.md
# ins_mem_seq

Parametrised, synchronous-read instruction memory for the MIPS-I core. It replaces the fixed combinational instruction ROM with a writable word array. Contents come from a built-in boot stub written at reset, and a program-load port can overwrite them later. Instruction fetch uses a registered request/response handshake with back-pressure, and the block flags misaligned and out-of-range fetch addresses.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 32-bit instruction words; power of two, ≥ 4.
- `IDX_W`, `$clog2(DEPTH_WORDS)`: word-index width (derived; not overridden).
- `BOOT_WORD0`, `32'h20000001`: reset content of word 0 (ADDI r0,r0,1).
- `BOOT_WORD1`, `32'h08000000`: reset content of word 1 (J 0).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `fetch_req` in 1: fetch request valid.
- `fetch_addr` in 32: byte address of the instruction.
- `fetch_ready` out 1: block can accept a request this cycle.
- `instruction` out 32: fetched word.
- `resp_valid` out 1: `instruction` and `fetch_fault` are valid.
- `resp_ready` in 1: consumer accepts the response.
- `fetch_fault` out 1: the response is for a misaligned or out-of-range address.
- `load_en` in 1: write one word.
- `load_addr` in 32: byte address for the load (word aligned).
- `load_data` in 32: word to write.
- `load_ready` out 1: load port active (state READY).
- `load_err` out 1: one-cycle pulse when a load is rejected.

## Operation
- States are INIT and READY.
- `reset` sends the block to INIT and clears the init counter `cnt` to 0. The same reset edge clears `resp_valid`, `fetch_fault` and `load_err`, and sets `instruction` to 0. Any pending response is discarded.
- INIT behaviour:
  - Each cycle writes `mem[cnt]`: `BOOT_WORD0` at index 0, `BOOT_WORD1` at index 1, 0 (NOP) elsewhere.
  - `cnt` increments; when `cnt == DEPTH_WORDS-1` the state moves to READY.
  - `fetch_ready = 0` and `load_ready = 0` throughout.
- READY is held until the next `reset`.
- Address decode, common to fetch and load:
  - Misaligned when `addr[1:0] != 0`.
  - Out of range when `addr[31:IDX_W+2] != 0`.
  - Index is `addr[IDX_W+1:2]`.
- Fetch:
  - `fetch_ready = (state == READY) && (!resp_valid || resp_ready)`.
  - A request is accepted when `fetch_req && fetch_ready`. On the next edge, `resp_valid <= 1`.
  - For a good address, the response carries `instruction <= mem[idx]` and `fetch_fault <= 0`.
  - For a bad address, it carries `instruction <= 0` and `fetch_fault <= 1`.
- Response hold:
  - While `resp_valid && !resp_ready`, `instruction` and `fetch_fault` stay stable and no new request is accepted.
  - If `resp_valid && resp_ready` and there is no new accept, `resp_valid <= 0`.
  - If `resp_valid && resp_ready` with a new accept, the next response is presented back-to-back.
- Load:
  - In READY, a write happens when `load_en` is high and `load_addr` is good: `mem[idx] <= load_data`.
  - `load_en` with a bad address, or `load_en` during INIT, writes nothing and pulses `load_err` high for one cycle.
- Simultaneous fetch and load to the same index return the old word (read-before-write). The new word is visible to fetches accepted on the following cycle or later.

## Timing
- Fetch latency is one cycle from accept to `resp_valid`. With `resp_ready` held high the block sustains one fetch per cycle.
- INIT lasts exactly `DEPTH_WORDS` cycles after the last `reset`-high edge. `fetch_ready` and `load_ready` first read 1 on cycle `DEPTH_WORDS` after the first edge with `reset` low.
- `load_err` is registered and appears on the edge after the offending `load_en`.
- Reset during INIT restarts the counter from 0. Reset during a stalled response drops that response: `resp_valid` is 0 on the next cycle.
- Memory contents are not cleared by reset beyond the INIT pass, which rewrites every word anyway.

## Test plan
- **Boot stub:**
  - Stimulus: reset, wait for `fetch_ready`, fetch 0x0, 0x4, 0x8 back-to-back with `resp_ready = 1`.
  - Required response: 0x20000001, 0x08000000, 0x00000000 on three consecutive cycles with `fetch_fault = 0`, and `fetch_ready` first high exactly `DEPTH_WORDS` cycles after reset release.
- **Faults:**
  - Stimulus: fetch 0x2, then 0x400 (with `DEPTH_WORDS = 256`).
  - Required response: both return `instruction = 0` and `fetch_fault = 1`.
  - Stimulus: `load_en` at 0x401.
  - Required response: `load_err` pulses once and memory is unchanged.
- **Load then fetch:**
  - Stimulus: load 0x00221820 at 0x10, then fetch 0x10.
  - Required response: 0x00221820.
  - Stimulus: in the same cycle, load 0xDEADBEEF at 0x10 and fetch 0x10.
  - Required response: the same-cycle fetch returns 0x00221820; a fetch on the next cycle returns 0xDEADBEEF.
- **Back-pressure:**
  - Stimulus: fetch 0x0 with `resp_ready = 0` for 3 cycles; hold `fetch_req` with 0x4.
  - Required response: `instruction` stays 0x20000001 with `resp_valid = 1` and `fetch_ready = 0`. One cycle after `resp_ready` rises, the response becomes 0x08000000.
- **Reset mid-operation:**
  - Stimulus: assert `reset` for 1 cycle while a response is stalled, and again at `cnt = 100` during INIT.
  - Required response: `resp_valid` is 0 next cycle; INIT restarts and lasts `DEPTH_WORDS` cycles from the new release. A word previously loaded at 0x10 reads 0 afterwards.
- **Load during INIT:**
  - Stimulus: `load_en` at 0x8 one cycle after reset release.
  - Required response: `load_err` pulses, and fetch 0x8 after INIT returns 0.
